// File: rtl/apb_bridge_master.sv
// APB master bridge: turns a valid/ready request/response port into APB transfers
// to up to NUM_SLAVES responders, one transfer outstanding, with an ACCESS-phase timeout.
module apb_bridge_master #(
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [31:0]                 req_addr,
   input  logic                        req_write,
   input  logic [31:0]                 req_wdata,
   input  logic [3:0]                  req_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [31:0]                 rsp_rdata,
   output logic                        rsp_err,
   output logic [NUM_SLAVES-1:0]       psel,
   output logic                        penable,
   output logic [15:0]                 paddr,
   output logic                        pwrite,
   output logic [31:0]                 pwdata,
   output logic [3:0]                  pwstrb,
   input  logic [NUM_SLAVES-1:0]       pready,
   input  logic [32*NUM_SLAVES-1:0]    prdata,
   input  logic [NUM_SLAVES-1:0]       pslverr
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                  state, state_nxt;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_hit;
   logic                    sel_ready;
   logic                    sel_err;
   logic [31:0]             sel_rdata;
   logic                    timeout_hit;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [NUM_SLAVES-1:0]   psel_nxt;
   logic                    penable_nxt;
   logic [15:0]             paddr_nxt;
   logic                    pwrite_nxt;
   logic [31:0]             pwdata_nxt;
   logic [3:0]              pwstrb_nxt;
   logic                    rsp_valid_nxt;
   logic [31:0]             rsp_rdata_nxt;
   logic                    rsp_err_nxt;

   assign req_ready = (state == IDLE);

   // psel is registered one-hot, so it doubles as the mux select for the
   // responder inputs; non-selected slaves therefore never leak through.
   always_comb begin
      dec_sel   = '0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         dec_sel[i] = (req_addr[19:16] == 4'(i));
         if (psel[i]) sel_rdata = sel_rdata | prdata[32*i +: 32];
      end
      dec_hit     = |dec_sel;
      sel_ready   = |(pready & psel);
      sel_err     = |(pslverr & psel);
      timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid) state_nxt = dec_hit ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (sel_ready || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of every registered output; pready wins over a same-cycle timeout.
   always_comb begin
      psel_nxt      = psel;
      penable_nxt   = penable;
      paddr_nxt     = paddr;
      pwrite_nxt    = pwrite;
      pwdata_nxt    = pwdata;
      pwstrb_nxt    = pwstrb;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      cnt_nxt       = cnt;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               paddr_nxt  = req_addr[15:0];
               pwrite_nxt = req_write;
               pwdata_nxt = req_wdata;
               pwstrb_nxt = req_write ? req_wstrb : 4'h0;
               if (dec_hit) begin
                  psel_nxt    = dec_sel;
                  penable_nxt = 1'b0;
               end else begin
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
               end
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            cnt_nxt     = '0;
         end
         ACCESS: begin
            if (sel_ready) begin
               psel_nxt      = '0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = sel_err;
               rsp_rdata_nxt = (!pwrite && !sel_err) ? sel_rdata : 32'h0;
            end else if (timeout_hit) begin
               psel_nxt      = '0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) rsp_valid_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psel      <= '0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pwstrb    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
      end else begin
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         paddr     <= paddr_nxt;
         pwrite    <= pwrite_nxt;
         pwdata    <= pwdata_nxt;
         pwstrb    <= pwstrb_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
         cnt       <= cnt_nxt;
      end
   end

endmodule
